// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo drain-side stream reader.
package fifo_pkg;

  // Reader FSM states; encoding is visible on the reader's state_o debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Default largest packet length in beats, and the matching counter width.
  localparam int MAX_PKT_BEATS_DEF = 256;
  localparam int CNT_W = $clog2(MAX_PKT_BEATS_DEF + 1);

endpackage

// File: rtl/fifo_axis_reader_skid.sv
// Two-entry circular buffer that absorbs the fifo read latency in front of the
// stream output. The writer must never write while full without a same-cycle read.
module skid_buf2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_rd;

  // A read only consumes an entry when one is present.
  assign do_rd = rd_en && (count != 2'd0);
  assign valid = (count != 2'd0);
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; a simultaneous write and read keep count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, do_rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drain side of the team fifo: pops words, buffers them through a 2-entry skid
// buffer and re-emits them as AXI-Stream beats framed into packets with tlast.
//
// Stream handshake: a beat transfers on a rising clk edge where m_axis_tvalid
// and m_axis_tready are both 1; while tvalid is high and tready low, tdata and
// tlast hold stable. fifo_pop_o is a request the fifo honours in the same cycle;
// its data appears on fifo_data_i one cycle later.
module fifo_axis_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable_i,
  input  logic [$clog2(MAX_PKT_BEATS+1)-1:0] pkt_beats_i,
  input  logic                               fifo_empty_i,
  output logic                               fifo_pop_o,
  input  logic [WIDTH-1:0]                   fifo_data_i,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic [WIDTH-1:0]                   m_axis_tdata,
  output logic                               m_axis_tlast,
  output logic                               busy_o,
  output logic                               pkt_done_o,
  output rd_state_t                          state_o
);

  localparam int CW = $clog2(MAX_PKT_BEATS + 1);

  rd_state_t        state;
  logic             pop_q;        // pop issued last cycle: its word lands this cycle
  logic [CW-1:0]    beat_cnt;
  logic [CW-1:0]    pkt_len;
  logic [CW-1:0]    cur_len;
  logic [CW-1:0]    last_idx;
  logic [CW-1:0]    beat_cnt_nxt;
  logic [CW-1:0]    remaining;
  logic [2:0]       outstanding;
  logic [1:0]       buf_count;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_head;
  logic             hs;
  logic             is_last;
  logic             pop_gate;

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pop_q),
    .wr_data (fifo_data_i),
    .rd_en   (m_axis_tready),
    .count   (buf_count),
    .head    (buf_head),
    .valid   (buf_valid)
  );

  // On the first beat the length comes straight from the input (0 means 1);
  // later beats use the value latched on that first beat.
  assign cur_len  = (beat_cnt == '0) ? ((pkt_beats_i == '0) ? CW'(1) : pkt_beats_i) : pkt_len;
  assign last_idx = cur_len - CW'(1);
  assign is_last  = (beat_cnt == last_idx);

  assign m_axis_tvalid = buf_valid;
  assign m_axis_tdata  = buf_head;
  assign m_axis_tlast  = buf_valid && is_last;
  assign hs            = buf_valid && m_axis_tready;
  assign pkt_done_o    = hs && is_last;

  assign beat_cnt_nxt = hs ? (is_last ? '0 : beat_cnt + CW'(1)) : beat_cnt;

  // Words already buffered or in flight, and beats still owed to the open packet.
  assign outstanding = {1'b0, buf_count} + {2'b00, pop_q};
  assign remaining   = pkt_len - beat_cnt;

  // Which states may request words: RUN prefetches freely while enabled; once
  // enable drops mid-packet only the words the open packet still needs are fetched.
  always_comb begin
    pop_gate = 1'b0;
    case (state)
      RUN:     pop_gate = enable_i || ((beat_cnt != '0) && (CW'(outstanding) < remaining));
      DRAIN:   pop_gate = (beat_cnt != '0) && (CW'(outstanding) < remaining);
      default: pop_gate = 1'b0;
    endcase
  end

  // Never pop back-to-back: the empty flag lags a pop by one cycle, so the
  // cycle after a pop cannot be trusted. Two outstanding words fill the buffer.
  assign fifo_pop_o = pop_gate && !fifo_empty_i && !pop_q && (outstanding < 3'd2);

  assign busy_o  = (state != IDLE) || buf_valid;
  assign state_o = state;

  // Reader FSM, in-flight tracking, beat counter and packet length latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pop_q    <= 1'b0;
      beat_cnt <= '0;
      pkt_len  <= '0;
    end else begin
      pop_q    <= fifo_pop_o;
      beat_cnt <= beat_cnt_nxt;
      if (hs && (beat_cnt == '0)) begin
        pkt_len <= cur_len;
      end
      case (state)
        IDLE:    if (enable_i) state <= RUN;
        RUN:     if (!enable_i) state <= (beat_cnt_nxt != '0) ? DRAIN : IDLE;
        DRAIN:   if (hs && is_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
